// File: rtl/legv8_ctrl_pkg.sv
// Shared types and encodings for the LEGv8 multi-cycle and pipelined control.
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CL_RTYPE, CL_LDUR, CL_STUR, CL_CBZ, CL_B, CL_ILLEGAL
  } instr_class_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
  localparam logic [5:0]  OP_B_PFX   = 6'b000101;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_PASS_B = 2'b01;
  localparam logic [1:0] ALU_FUNC   = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM    = 2'b10;
  localparam logic [1:0] CAUSE_DMEM    = 2'b11;

endpackage

// File: rtl/legv8_opcode_decode.sv
// Combinational opcode -> instruction class decoder, shared with the pipelined control.
module legv8_opcode_decode
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0]  opcode,
  output instr_class_t iclass
);

  always_comb begin
    iclass = CL_ILLEGAL;
    if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR)
      iclass = CL_RTYPE;
    else if (opcode == OP_LDUR)
      iclass = CL_LDUR;
    else if (opcode == OP_STUR)
      iclass = CL_STUR;
    else if (opcode[10:3] == OP_CBZ_PFX)
      iclass = CL_CBZ;
    else if (opcode[10:5] == OP_B_PFX)
      iclass = CL_B;
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 sequencer: FETCH/DECODE/EXEC/MEM/WB with memory timeouts and retire count.
module legv8_multicycle_ctrl
  import legv8_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [10:0]      OPCODE,
  input  logic             ALU_ZERO,
  input  logic             IMEM_READY,
  input  logic             DMEM_READY,
  output logic             IMEM_REQ,
  output logic             IR_WRITE,
  output logic             DMEM_REQ,
  output logic             DMEM_WE,
  output logic             REG2LOC,
  output logic             ALUSRC,
  output logic [1:0]       ALU_OP,
  output logic             REGWRITE,
  output logic             MEM2REG,
  output logic             PC_WRITE,
  output logic             PC_SRC,
  output logic             TRAP,
  output logic [1:0]       TRAP_CAUSE,
  output logic [CNT_W-1:0] INSTR_COUNT
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  state_t             state, state_nxt;
  instr_class_t       cls_q, cls_dec;
  logic [1:0]         cause_q, cause_nxt;
  logic [WAIT_W-1:0]  wait_q;
  logic               wait_inc;
  logic [CNT_W-1:0]   count_q;

  legv8_opcode_decode u_decode (
    .opcode (OPCODE),
    .iclass (cls_dec)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state   <= ST_FETCH;
      cls_q   <= CL_ILLEGAL;
      cause_q <= CAUSE_NONE;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state   <= state_nxt;
      cause_q <= cause_nxt;
      if (state == ST_DECODE)
        cls_q <= cls_dec;
      if (state_nxt != state)
        wait_q <= '0;
      else if (wait_inc)
        wait_q <= wait_q + 1'b1;
      if (PC_WRITE)
        count_q <= count_q + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cause_nxt = cause_q;
    wait_inc  = 1'b0;
    IMEM_REQ  = 1'b0;
    IR_WRITE  = 1'b0;
    DMEM_REQ  = 1'b0;
    DMEM_WE   = 1'b0;
    REG2LOC   = 1'b0;
    ALUSRC    = 1'b0;
    ALU_OP    = ALU_ADD;
    REGWRITE  = 1'b0;
    MEM2REG   = 1'b0;
    PC_WRITE  = 1'b0;
    PC_SRC    = 1'b0;
    TRAP      = 1'b0;
    case (state)
      ST_FETCH: begin
        // Suppress the request while reset is held so nothing leaks during abort.
        if (!RESET) begin
          IMEM_REQ = 1'b1;
          if (IMEM_READY) begin
            IR_WRITE  = 1'b1;
            state_nxt = ST_DECODE;
          end else if (wait_q == WAIT_MAX) begin
            state_nxt = ST_TRAP;
            cause_nxt = CAUSE_IMEM;
          end else begin
            wait_inc = 1'b1;
          end
        end
      end
      ST_DECODE: begin
        REG2LOC = (cls_dec == CL_STUR) || (cls_dec == CL_CBZ);
        if (cls_dec == CL_ILLEGAL) begin
          state_nxt = ST_TRAP;
          cause_nxt = CAUSE_ILLEGAL;
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CL_RTYPE: begin
            ALU_OP    = ALU_FUNC;
            state_nxt = ST_WB;
          end
          CL_LDUR, CL_STUR: begin
            ALU_OP    = ALU_ADD;
            ALUSRC    = 1'b1;
            state_nxt = ST_MEM;
          end
          CL_CBZ: begin
            ALU_OP    = ALU_PASS_B;
            REG2LOC   = 1'b1;
            PC_WRITE  = 1'b1;
            PC_SRC    = ALU_ZERO;
            state_nxt = ST_FETCH;
          end
          CL_B: begin
            PC_WRITE  = 1'b1;
            PC_SRC    = 1'b1;
            state_nxt = ST_FETCH;
          end
          default: begin
            state_nxt = ST_TRAP;
            cause_nxt = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_MEM: begin
        DMEM_REQ = 1'b1;
        ALUSRC   = 1'b1;
        DMEM_WE  = (cls_q == CL_STUR);
        if (DMEM_READY) begin
          if (cls_q == CL_STUR) begin
            PC_WRITE  = 1'b1;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_WB;
          end
        end else if (wait_q == WAIT_MAX) begin
          state_nxt = ST_TRAP;
          cause_nxt = CAUSE_DMEM;
        end else begin
          wait_inc = 1'b1;
        end
      end
      ST_WB: begin
        REGWRITE  = 1'b1;
        MEM2REG   = (cls_q == CL_LDUR);
        PC_WRITE  = 1'b1;
        state_nxt = ST_FETCH;
      end
      ST_TRAP: begin
        TRAP = 1'b1;
      end
      default: begin
        state_nxt = ST_FETCH;
      end
    endcase
  end

  assign TRAP_CAUSE  = cause_q;
  assign INSTR_COUNT = count_q;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Self-checking bench: per-cycle expected strobe schedules built from instruction-level rules.
module tb_legv8_multicycle_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;

  localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_B = 4, C_ILL = 5;

  // Observed vector: {imreq, irw, dreq, dwe, r2l, asrc, aop[1:0], rw, m2r, pcw, pcs, trap, cause[1:0]}
  localparam logic [14:0] M_IMREQ = 15'h4000;
  localparam logic [14:0] M_IRW   = 15'h2000;
  localparam logic [14:0] M_DREQ  = 15'h1000;
  localparam logic [14:0] M_DWE   = 15'h0800;
  localparam logic [14:0] M_R2L   = 15'h0400;
  localparam logic [14:0] M_ASRC  = 15'h0200;
  localparam logic [14:0] M_AOP01 = 15'h0080;
  localparam logic [14:0] M_AOP10 = 15'h0100;
  localparam logic [14:0] M_RW    = 15'h0040;
  localparam logic [14:0] M_M2R   = 15'h0020;
  localparam logic [14:0] M_PCW   = 15'h0010;
  localparam logic [14:0] M_PCS   = 15'h0008;
  localparam logic [14:0] M_TRAP  = 15'h0004;

  logic             CLOCK = 1'b0;
  logic             RESET = 1'b1;
  logic [10:0]      OPCODE = '0;
  logic             ALU_ZERO = 1'b0;
  logic             IMEM_READY = 1'b0;
  logic             DMEM_READY = 1'b0;
  logic             IMEM_REQ, IR_WRITE, DMEM_REQ, DMEM_WE, REG2LOC, ALUSRC;
  logic [1:0]       ALU_OP;
  logic             REGWRITE, MEM2REG, PC_WRITE, PC_SRC, TRAP;
  logic [1:0]       TRAP_CAUSE;
  logic [CNT_W-1:0] INSTR_COUNT;
  logic [14:0]      obs;

  legv8_multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .OPCODE(OPCODE), .ALU_ZERO(ALU_ZERO),
    .IMEM_READY(IMEM_READY), .DMEM_READY(DMEM_READY),
    .IMEM_REQ(IMEM_REQ), .IR_WRITE(IR_WRITE), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE),
    .REG2LOC(REG2LOC), .ALUSRC(ALUSRC), .ALU_OP(ALU_OP), .REGWRITE(REGWRITE),
    .MEM2REG(MEM2REG), .PC_WRITE(PC_WRITE), .PC_SRC(PC_SRC), .TRAP(TRAP),
    .TRAP_CAUSE(TRAP_CAUSE), .INSTR_COUNT(INSTR_COUNT)
  );

  always #5 CLOCK = ~CLOCK;

  assign obs = {IMEM_REQ, IR_WRITE, DMEM_REQ, DMEM_WE, REG2LOC, ALUSRC, ALU_OP,
                REGWRITE, MEM2REG, PC_WRITE, PC_SRC, TRAP, TRAP_CAUSE};

  typedef struct {
    bit          ir;
    bit          dr;
    bit          z;
    logic [14:0] exp;
  } cyc_t;

  cyc_t        sched[$];
  int          tests = 0;
  int          failures = 0;
  logic [CNT_W-1:0] model_count = '0;
  bit          model_retires;

  function automatic int classify(input logic [10:0] op);
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return C_R;
    if (op == 11'b11111000010) return C_LD;
    if (op == 11'b11111000000) return C_ST;
    if (op[10:3] == 8'b10110100) return C_CBZ;
    if (op[10:5] == 6'b000101) return C_B;
    return C_ILL;
  endfunction

  function automatic logic [10:0] make_op(input int cls);
    logic [10:0] op;
    logic [10:0] rtab [4];
    rtab[0] = 11'b10001011000; rtab[1] = 11'b11001011000;
    rtab[2] = 11'b10001010000; rtab[3] = 11'b10101010000;
    case (cls)
      C_R:   op = rtab[$urandom_range(0, 3)];
      C_LD:  op = 11'b11111000010;
      C_ST:  op = 11'b11111000000;
      C_CBZ: op = {8'b10110100, 3'($urandom)};
      C_B:   op = {6'b000101, 5'($urandom)};
      default: begin
        op = 11'($urandom);
        while (classify(op) != C_ILL) op = 11'($urandom);
      end
    endcase
    return op;
  endfunction

  function automatic void push(input bit ir, input bit dr, input bit z, input logic [14:0] e);
    cyc_t c;
    c.ir = ir; c.dr = dr; c.z = z; c.exp = e;
    sched.push_back(c);
  endfunction

  function automatic void push_trap(input logic [1:0] cause);
    for (int i = 0; i < 20; i++)
      push(1'($urandom), 1'($urandom), 1'($urandom), M_TRAP | {13'b0, cause});
  endfunction

  // Ready delays above TIMEOUT mean the memory never answers in time.
  function automatic void build(input logic [10:0] op, input int di, input int dd, input bit z);
    int cls;
    int n;
    cls = classify(op);
    sched.delete();
    model_retires = 1'b0;
    n = (di > TIMEOUT) ? TIMEOUT + 1 : di;
    for (int i = 0; i < n; i++) push(1'b0, 1'($urandom), 1'($urandom), M_IMREQ);
    if (di > TIMEOUT) begin push_trap(2'b10); return; end
    push(1'b1, 1'($urandom), 1'($urandom), M_IMREQ | M_IRW);
    push(1'($urandom), 1'($urandom), 1'($urandom), (cls == C_ST || cls == C_CBZ) ? M_R2L : 15'h0);
    if (cls == C_ILL) begin push_trap(2'b01); return; end
    case (cls)
      C_R: begin
        push(1'($urandom), 1'($urandom), 1'($urandom), M_AOP10);
        push(1'($urandom), 1'($urandom), 1'($urandom), M_RW | M_PCW);
      end
      C_CBZ: push(1'($urandom), 1'($urandom), z, M_AOP01 | M_R2L | M_PCW | (z ? M_PCS : 15'h0));
      C_B:   push(1'($urandom), 1'($urandom), 1'($urandom), M_PCW | M_PCS);
      default: begin
        push(1'($urandom), 1'($urandom), 1'($urandom), M_ASRC);
        n = (dd > TIMEOUT) ? TIMEOUT + 1 : dd;
        for (int i = 0; i < n; i++)
          push(1'($urandom), 1'b0, 1'($urandom), M_DREQ | M_ASRC | ((cls == C_ST) ? M_DWE : 15'h0));
        if (dd > TIMEOUT) begin push_trap(2'b11); return; end
        if (cls == C_ST)
          push(1'($urandom), 1'b1, 1'($urandom), M_DREQ | M_ASRC | M_DWE | M_PCW);
        else begin
          push(1'($urandom), 1'b1, 1'($urandom), M_DREQ | M_ASRC);
          push(1'($urandom), 1'($urandom), 1'($urandom), M_RW | M_M2R | M_PCW);
        end
      end
    endcase
    model_retires = 1'b1;
  endfunction

  task automatic play(input string name, input int n);
    int lim;
    lim = (n < 0 || n > sched.size()) ? sched.size() : n;
    for (int i = 0; i < lim; i++) begin
      @(negedge CLOCK);
      IMEM_READY = sched[i].ir;
      DMEM_READY = sched[i].dr;
      ALU_ZERO   = sched[i].z;
      #1;
      tests++;
      if (obs !== sched[i].exp) begin
        failures++;
        $display("FAIL %s cycle %0d: strobes got %b expected %b", name, i, obs, sched[i].exp);
      end
    end
  endtask

  task automatic run_instr(input string name, input logic [10:0] op, input int di, input int dd, input bit z);
    OPCODE = op;
    build(op, di, dd, z);
    play(name, -1);
    if (model_retires) model_count = model_count + 1'b1;
    @(posedge CLOCK);
    #1;
    tests++;
    if (INSTR_COUNT !== model_count) begin
      failures++;
      $display("FAIL %s count: got %0d expected %0d", name, INSTR_COUNT, model_count);
    end
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    RESET = 1'b1;
    IMEM_READY = 1'b0; DMEM_READY = 1'b0; ALU_ZERO = 1'b0;
    model_count = '0;
    #1;
    tests++;
    if (obs !== 15'h0 || INSTR_COUNT !== '0) begin
      failures++;
      $display("FAIL reset_hold: strobes %b count %0d expected all zero", obs, INSTR_COUNT);
    end
    @(posedge CLOCK);
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLOCK);
    #1;
    tests++;
    if (obs !== M_IMREQ || INSTR_COUNT !== '0) begin
      failures++;
      $display("FAIL reset_fetch: strobes %b count %0d expected %b count 0", obs, INSTR_COUNT, M_IMREQ);
    end
    do_reset();
  endtask

  task automatic test_add();
    run_instr("add", 11'b10001011000, 0, 0, 1'b0);
  endtask

  task automatic test_ldur_delayed();
    run_instr("ldur_wait3", 11'b11111000010, 0, 3, 1'b0);
  endtask

  task automatic test_cbz_pair();
    run_instr("cbz_taken", make_op(C_CBZ), 0, 0, 1'b1);
    run_instr("cbz_not_taken", make_op(C_CBZ), 0, 0, 1'b0);
  endtask

  task automatic test_illegal();
    run_instr("illegal_all_ones", 11'b11111111111, 0, 0, 1'b0);
    do_reset();
    run_instr("illegal_random", make_op(C_ILL), 1, 0, 1'b0);
    do_reset();
  endtask

  task automatic test_timeouts();
    run_instr("imem_ready_at_limit", make_op(C_B), TIMEOUT, 0, 1'b0);
    run_instr("dmem_ready_at_limit", 11'b11111000000, 0, TIMEOUT, 1'b0);
    run_instr("imem_timeout", make_op(C_R), TIMEOUT + 1, 0, 1'b0);
    do_reset();
    run_instr("dmem_timeout", 11'b11111000010, 0, TIMEOUT + 1, 1'b0);
    do_reset();
  endtask

  task automatic test_reset_mid_stur();
    run_instr("pre_add", make_op(C_R), 0, 0, 1'b0);
    OPCODE = 11'b11111000000;
    build(OPCODE, 0, 6, 1'b0);
    play("stur_pre_reset", 5);
    @(negedge CLOCK);
    RESET = 1'b1;
    model_count = '0;
    #1;
    tests++;
    if (obs !== 15'h0 || INSTR_COUNT !== '0) begin
      failures++;
      $display("FAIL stur_abort: strobes %b count %0d expected all zero", obs, INSTR_COUNT);
    end
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    run_instr("post_reset_stur", 11'b11111000000, 0, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int cls, di, dd;
    for (int k = 0; k < 60; k++) begin
      cls = $urandom_range(C_R, C_B);
      di  = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, 3);
      dd  = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, 3);
      run_instr("random", make_op(cls), di, dd, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldur_delayed();
    test_cbz_pair();
    test_illegal();
    test_timeouts();
    test_reset_mid_stur();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
